serial_add_arbiter: RTL and testbench

Bit-serial adder sequencer that shares one `full_adder` instance between two requesters. Each requester hands over a WIDTH-bit operand pair over valid/ready. The block picks a requester round-robin, drives the adder LSB-first for WIDTH cycles with a registered carry, and returns sum, carry-out and requester id over a result valid/ready port. It sits in front of the systolic cell datapath as the arbiter for the shared adder resource.

---
 rtl/serial_add_arbiter_pkg.sv | 9 +
 rtl/serial_add_arbiter_full_adder.sv | 15 +
 rtl/serial_add_arbiter.sv | 107 ++++++++++
 tb/tb_serial_add_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_arbiter_pkg.sv
// serial_add_pkg: shared constants for the serial adder arbiter.
//   IDLE/RUN/DONE : FSM state encodings
//   SA_WIDTH      : default operand width
package serial_add_pkg;
    localparam int         SA_WIDTH = 8;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
endpackage

// File: rtl/serial_add_arbiter_full_adder.sv
// full_adder: one-bit full adder with output enable.
//   a, b, cin : addend bits and carry in
//   en        : drive outputs; when low both outputs float (Z)
//   out, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    output wire  out,
    output wire  cout
);
    assign out  = en ? (a ^ b ^ cin) : 1'bz;
    assign cout = en ? ((a & b) | (cin & (a ^ b))) : 1'bz;
endmodule

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin sharing of one bit-serial full adder
// between two requesters.
//   clk, rst                    : clock, synchronous active-high reset
//   req{0,1}_valid/ready/a/b    : operand pair handshakes
//   res_valid/ready             : result handshake
//   res_sum, res_cout, res_id   : sum mod 2^WIDTH, carry out, owner
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic             last_id, cur_id, carry;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             grant0, grant1, fa_en;
    wire              fa_out, fa_cout;

    // Tie goes to whoever was not served last.
    assign grant0 = req0_valid && (!req1_valid || last_id);
    assign grant1 = req1_valid && (!req0_valid || !last_id);
    // Readies held low while reset is asserted even though state reads IDLE.
    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;

    assign fa_en     = (state == RUN);
    assign res_valid = (state == DONE);
    assign res_sum   = sum_sh;
    assign res_cout  = carry;
    assign res_id    = cur_id;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .en   (fa_en),
        .out  (fa_out),
        .cout (fa_cout)
    );

    // Sum fills from the MSB side so after WIDTH shifts bit 0 lands at LSB.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = fa_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_id <= 1'b1;
            cur_id  <= 1'b0;
            carry   <= 1'b0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_sh   <= req1_ready ? req1_a : req0_a;
                        b_sh   <= req1_ready ? req1_b : req0_b;
                        cur_id <= req1_ready;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Adder outputs are only driven here; never sampled elsewhere.
                    sum_sh <= sum_nxt;
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        last_id <= cur_id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed vectors for serial_add_arbiter (WIDTH=8).
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id;
    logic [W-1:0] res_sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hs_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Waits for a grant, checks owner, latency and result, then retires it.
    // keep: leave the granted valid high; hold: cycles of res_ready=0 in DONE.
    task automatic run_one(input bit eid, input logic [W-1:0] es, input bit ec,
                           input bit keep, input int hold);
        int n;
        int lat;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 40) begin
            tick();
            n++;
        end
        chk("hs_timeout", 32'(n < 40), 1);
        chk("grant_id", req1_ready, eid);
        hs_cyc = cyc;
        tick();
        if (!keep) begin
            if (eid) req1_valid = 1'b0;
            else     req0_valid = 1'b0;
        end
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("sum", res_sum, es);
        chk("cout", res_cout, ec);
        chk("id", res_id, eid);
        if (hold > 0) begin
            res_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("bp_valid", res_valid, 1);
                chk("bp_sum", res_sum, es);
                chk("bp_cout", res_cout, ec);
                chk("bp_id", res_id, eid);
                chk("bp_rdy", {req0_ready, req1_ready}, 0);
            end
            res_ready = 1'b1;
        end
        tick();
        chk("done_exit", res_valid, 0);
    endtask

    initial begin
        int prev;
        int seen;

        // Reset with both requesters pending.
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h3C;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", res_valid, 0);
            chk("rst_sum", res_sum, 0);
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
        end
        rst = 1'b0;
        #1;
        chk("first_rdy0", req0_ready, 1);
        chk("first_rdy1", req1_ready, 0);

        run_one(1'b0, 8'h96, 1'b0, 1'b0, 0);   // 5A+3C
        run_one(1'b1, 8'h00, 1'b1, 1'b0, 0);   // FF+01 overflow

        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        run_one(1'b0, 8'hFE, 1'b1, 1'b0, 0);
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80;
        run_one(1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Contention: strict alternation, 10 cycles per op.
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h0F;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_one(1'b0, 8'h03, 1'b0, 1'b1, 0);
            else            run_one(1'b1, 8'h1F, 1'b0, 1'b1, 0);
            if (i > 0) chk("op_spacing", hs_cyc - prev, W + 2);
            prev = hs_cyc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure with req1 waiting; it must be taken right after DONE.
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h01;
        run_one(1'b0, 8'h46, 1'b0, 1'b0, 5);
        chk("bp_next_rdy", req1_ready, 1);
        run_one(1'b1, 8'h10, 1'b0, 1'b0, 0);

        // Reset on the 4th RUN cycle abandons the op.
        req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'hAA;
        #1;
        chk("mid_rdy", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("mid_no_valid", seen, 0);
        chk("mid_sum_clr", res_sum, 0);
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
        run_one(1'b0, 8'h30, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
